// File: rtl/seq_stream_ctrl_if.sv
// Word-in / bit-out bus for seq_stream_ctrl: producer handshake, clear, and
// the serial stream plus detection results.
interface seq_stream_ctrl_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              clear;
    logic              bit_out;
    logic              bit_valid;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic              done;

    // Producer / sequencing side
    modport master (
        output in_valid, in_data, clear,
        input  in_ready, bit_out, bit_valid, match, match_cnt, done
    );

    // Controller side
    modport slave (
        input  in_valid, in_data, clear,
        output in_ready, bit_out, bit_valid, match, match_cnt, done
    );
endinterface

// File: rtl/seq_stream_ctrl.sv
// Serialises words MSB-first and runs a pattern detector over the bit stream,
// producing a registered match pulse and a saturating match count.
module seq_stream_ctrl #(
    parameter int unsigned      WORD_W  = 8,
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b0,
    parameter int unsigned      CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    seq_stream_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(WORD_W);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              bit_out;
    logic              bit_valid;
    logic              done;

    logic [PAT_W-1:0]  history;
    logic [LEN_W-1:0]  hist_len;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;

    logic [PAT_W-1:0]  hist_next;
    logic              hit;

    // Detector view of the bit currently on bit_out
    always_comb begin
        hist_next = {history[PAT_W-2:0], bit_out};
        hit       = bit_valid && (hist_next == PATTERN) &&
                    (hist_len >= LEN_W'(PAT_W - 1));
    end

    // Word sequencer: accept in IDLE, shift WORD_W bits, pulse done, return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            shreg     <= '0;
            idx       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        // First bit goes out straight away; shreg holds the rest
                        bit_out   <= bus.in_data[WORD_W-1];
                        bit_valid <= 1'b1;
                        shreg     <= bus.in_data << 1;
                        idx       <= IDX_W'(WORD_W - 1);
                        state     <= StShift;
                    end
                end
                StShift: begin
                    if (idx == '0) begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= StDone;
                    end else begin
                        bit_out <= shreg[WORD_W-1];
                        shreg   <= shreg << 1;
                        idx     <= idx - IDX_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Pattern history, match pulse and saturating counter; clear beats a hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history   <= '0;
            hist_len  <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (bus.clear) begin
            history   <= '0;
            hist_len  <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;
            if (bit_valid) begin
                if (hit && !OVERLAP) begin
                    history  <= '0;
                    hist_len <= '0;
                end else begin
                    history <= hist_next;
                    if (hist_len != LEN_W'(PAT_W)) begin
                        hist_len <= hist_len + LEN_W'(1);
                    end
                end
                if (hit && (match_cnt != {CNT_W{1'b1}})) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (state == StIdle);
    assign bus.bit_out   = bit_out;
    assign bus.bit_valid = bit_valid;
    assign bus.match     = match;
    assign bus.match_cnt = match_cnt;
    assign bus.done      = done;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl. Two instances share the same stimulus:
// dut0 uses the default parameters, dut1 uses OVERLAP=1 and CNT_W=2.
module tb_seq_stream_ctrl;

    localparam int unsigned PAT_V = 4'b1010;

    typedef struct {
        bit          b;
        bit          hit;
        int unsigned cnt;
        bit          last;
    } exp_t;

    logic clk;
    logic rst;

    seq_stream_ctrl_if #(.WORD_W(8), .CNT_W(8)) bus0 ();
    seq_stream_ctrl_if #(.WORD_W(8), .CNT_W(2)) bus1 ();

    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_data  = bus0.in_data;
    assign bus1.clear    = bus0.clear;

    seq_stream_ctrl #(
        .WORD_W(8), .PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    seq_stream_ctrl #(
        .WORD_W(8), .PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: recent bits since last restart, and counts
    bit          h0[$];
    bit          h1[$];
    int unsigned c0 = 0;
    int unsigned c1 = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    int          clr_bit   = -1;
    bit          hold_mode = 1'b0;
    int unsigned hold_cnt  = 0;
    int unsigned cyc       = 0;
    int unsigned last_acc  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned pack(input bit q[$]);
        int unsigned v = 0;
        foreach (q[i]) v = (v << 1) | int'(q[i]);
        return v;
    endfunction

    // One bit through the behavioural detector of instance inst
    task automatic model_bit(input int inst, input bit b, input bit clr,
                             output bit hit, output int unsigned cnt);
        bit          h[$];
        int unsigned c;
        int unsigned mx;
        bit          ovl;
        if (inst == 0) begin h = h0; c = c0; ovl = 1'b0; mx = 255; end
        else           begin h = h1; c = c1; ovl = 1'b1; mx = 3;   end
        hit = 1'b0;
        if (clr) begin
            h.delete();
            c = 0;
        end else begin
            h.push_back(b);
            if (h.size() > 4) void'(h.pop_front());
            hit = (h.size() == 4) && (pack(h) == PAT_V);
            if (hit) begin
                if (!ovl) h.delete();
                if (c < mx) c++;
            end
        end
        cnt = c;
        if (inst == 0) begin h0 = h; c0 = c; end
        else           begin h1 = h; c1 = c; end
    endtask

    task automatic model_reset();
        h0.delete(); h1.delete();
        c0 = 0; c1 = 0;
    endtask

    // Accept watcher: every handshake pushes the expected per-bit results
    bit          wb;
    bit          whit;
    int unsigned wcnt;
    exp_t        we;
    always @(posedge clk) begin
        cyc++;
        if (rst && bus0.in_valid && bus0.in_ready) begin
            if (hold_mode) begin
                if (hold_cnt > 0) chk("hold_gap", cyc - last_acc, 10);
                hold_cnt++;
            end else begin
                hold_cnt = 0;
            end
            last_acc = cyc;
            for (int k = 0; k < 8; k++) begin
                wb = bus0.in_data[7-k];
                model_bit(0, wb, k == clr_bit, whit, wcnt);
                we.b = wb; we.hit = whit; we.cnt = wcnt; we.last = (k == 7);
                q0.push_back(we);
                model_bit(1, wb, k == clr_bit, whit, wcnt);
                we.hit = whit; we.cnt = wcnt;
                q1.push_back(we);
            end
        end
    end

    // Monitor for dut0
    bit   pend0 = 1'b0;
    exp_t pe0;
    always @(negedge clk) begin
        if (!rst) begin
            pend0 = 1'b0;
        end else begin
            if (pend0) begin
                chk("match0", bus0.match, pe0.hit);
                chk("cnt0", bus0.match_cnt, pe0.cnt);
                chk("done0", bus0.done, pe0.last);
            end else begin
                chk("match0_quiet", bus0.match, 0);
                chk("done0_quiet", bus0.done, 0);
            end
            pend0 = 1'b0;
            if (bus0.bit_valid) begin
                chk("exp0_avail", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    pe0 = q0.pop_front();
                    chk("bit0", bus0.bit_out, pe0.b);
                    pend0 = 1'b1;
                end
            end
        end
    end

    // Monitor for dut1
    bit   pend1 = 1'b0;
    exp_t pe1;
    always @(negedge clk) begin
        if (!rst) begin
            pend1 = 1'b0;
        end else begin
            if (pend1) begin
                chk("match1", bus1.match, pe1.hit);
                chk("cnt1", bus1.match_cnt, pe1.cnt);
                chk("done1", bus1.done, pe1.last);
            end else begin
                chk("match1_quiet", bus1.match, 0);
                chk("done1_quiet", bus1.done, 0);
            end
            pend1 = 1'b0;
            if (bus1.bit_valid) begin
                chk("exp1_avail", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    pe1 = q1.pop_front();
                    chk("bit1", bus1.bit_out, pe1.b);
                    pend1 = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (!bus0.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("idle_wait", bus0.in_ready, 1);
    endtask

    task automatic send(input logic [7:0] d, input int clr_at);
        wait_idle();
        clr_bit       = clr_at;
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        if (clr_at >= 0) begin
            repeat (clr_at) @(negedge clk);
            bus0.clear = 1'b1;
            @(negedge clk);
            bus0.clear = 1'b0;
        end
        clr_bit = -1;
    endtask

    task automatic idle_clear();
        wait_idle();
        bus0.clear = 1'b1;
        model_reset();
        @(negedge clk);
        bus0.clear = 1'b0;
        chk("clear_cnt0", bus0.match_cnt, 0);
        chk("clear_cnt1", bus1.match_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.in_data  = '0;
        bus0.clear    = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_bit_valid", bus0.bit_valid, 0);
        chk("rst_match", bus0.match, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_cnt", bus0.match_cnt, 0);
        chk("rst_bit_out", bus0.bit_out, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus0.in_ready, 1);

        // T1: in_valid held high, one accept per 10 cycles
        hold_mode     = 1'b1;
        bus0.in_data  = 8'hA5;
        bus0.in_valid = 1'b1;
        repeat (25) @(negedge clk);
        bus0.in_valid = 1'b0;
        hold_mode     = 1'b0;
        chk("hold_accepts", hold_cnt, 3);

        // T2/T3: 1010_1010
        idle_clear();
        send(8'hAA, -1);
        wait_idle();
        chk("t2_cnt0", bus0.match_cnt, 2);
        chk("t3_cnt1", bus1.match_cnt, 3);

        // T4: pattern spans a word boundary
        idle_clear();
        send(8'h05, -1);
        send(8'h7F, -1);
        wait_idle();
        chk("t4_cnt0", bus0.match_cnt, 1);

        // T5: saturation on the 2-bit counter
        idle_clear();
        repeat (4) send(8'hAA, -1);
        wait_idle();
        chk("t5_cnt0", bus0.match_cnt, 8);
        chk("t5_cnt1_sat", bus1.match_cnt, 3);

        // T6: clear coincides with the hit on bit 3
        idle_clear();
        send(8'hAA, 3);
        wait_idle();
        chk("t6_cnt0", bus0.match_cnt, 1);
        chk("t6_cnt1", bus1.match_cnt, 1);

        // Random words with occasional mid-word and idle clears
        for (int i = 0; i < 30; i++) begin
            int ca;
            ca = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            send(8'($urandom), ca);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) idle_clear();
        end

        // Reset during bit 3 of a word
        wait_idle();
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'hC3;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        q0.delete(); q1.delete();
        model_reset();
        @(negedge clk);
        chk("mid_rst_bit_valid", bus0.bit_valid, 0);
        chk("mid_rst_done", bus0.done, 0);
        chk("mid_rst_cnt", bus0.match_cnt, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", bus0.in_ready, 1);
        repeat (10) @(negedge clk);
        send(8'h5A, -1);
        send(8'hA0, -1);
        wait_idle();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("final_cnt0", bus0.match_cnt, c0);
        chk("final_cnt1", bus1.match_cnt, c1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
